// File: rtl/sid_voice_bank_if.sv
// Bus between the SID register file and the voice bank: per-voice controls in,
// scaled samples, osc3 readback and the sample strobe out.
interface sid_voice_bank_if #(
  parameter int NUM_VOICES = 3,
  parameter int OUT_W      = 12,
  parameter int VOL_W      = 8
);
  logic                        ce;
  logic [NUM_VOICES*16-1:0]    freq;
  logic [NUM_VOICES*OUT_W-1:0] pw;
  logic [NUM_VOICES*8-1:0]     ctrl;
  logic [NUM_VOICES*VOL_W-1:0] vol;
  logic [NUM_VOICES*OUT_W-1:0] wave_out;
  logic [7:0]                  osc3;
  logic                        out_valid;

  modport master (
    output ce, freq, pw, ctrl, vol,
    input  wave_out, osc3, out_valid
  );

  modport slave (
    input  ce, freq, pw, ctrl, vol,
    output wave_out, osc3, out_valid
  );
endinterface

// File: rtl/sid_voice_bank.sv
// N-voice SID oscillator bank: phase accumulators and noise LFSRs advance on ce,
// waveforms are combined, scaled and registered one clk later.
module sid_voice_bank #(
  parameter int NUM_VOICES = 3,
  parameter int ACC_W      = 24,
  parameter int OUT_W      = 12,
  parameter int LFSR_W     = 23,
  parameter int VOL_W      = 8
) (
  input logic            clk,
  input logic            reset,
  sid_voice_bank_if.slave bus
);
  localparam int MSB    = ACC_W - 1;
  localparam int NBIT   = ACC_W - 5;
  localparam int LAST   = NUM_VOICES - 1;
  localparam int PROD_W = OUT_W + VOL_W;

  typedef logic [ACC_W-1:0]  acc_t;
  typedef logic [LFSR_W-1:0] lfsr_t;
  typedef logic [OUT_W-1:0]  samp_t;

  function automatic int prev_voice(input int v);
    return (v == 0) ? LAST : v - 1;
  endfunction

  function automatic lfsr_t lfsr_step(input lfsr_t l);
    return {l[LFSR_W-2:0], l[22] ^ l[17]};
  endfunction

  function automatic samp_t waveform(input acc_t acc, input logic ring_msb, input lfsr_t l,
                                     input logic [7:0] cv, input samp_t pw_v);
    samp_t top, tri_w, pulse_w, noise_w, raw;
    top     = acc[MSB -: OUT_W];
    tri_w   = {acc[ACC_W-2 -: OUT_W-1], 1'b0};
    tri_w   = (acc[MSB] ^ (cv[2] & ring_msb)) ? ~tri_w : tri_w;
    pulse_w = (top < pw_v) ? '1 : '0;
    noise_w = '0;
    noise_w[OUT_W-1 -: 8] = {l[20], l[18], l[14], l[11], l[9], l[5], l[2], l[0]};
    raw = '1;
    raw = cv[4] ? (raw & tri_w)   : raw;
    raw = cv[5] ? (raw & top)     : raw;
    raw = cv[6] ? (raw & pulse_w) : raw;
    raw = cv[7] ? (raw & noise_w) : raw;
    return (cv[7:4] == 4'b0000) ? '0 : raw;
  endfunction

  function automatic samp_t scale(input samp_t raw, input logic [VOL_W-1:0] v);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(raw) * PROD_W'(v);
    return prod[VOL_W +: OUT_W];
  endfunction

  acc_t  [NUM_VOICES-1:0]      acc_q, acc_d, sum_s;
  lfsr_t [NUM_VOICES-1:0]      lfsr_q, lfsr_d;
  samp_t [NUM_VOICES-1:0]      raw_s;
  logic  [NUM_VOICES-1:0]      prev_msb_q, prev_msb_d, prev_nbit_q, prev_nbit_d, rise_s;
  logic  [NUM_VOICES*OUT_W-1:0] wave_q, wave_d;
  logic  [7:0]                 osc3_q, osc3_d;
  logic                        ce_q, ce_d, out_valid_q, out_valid_d;
  logic                        unused_gate_s;

  // Sync detection looks at the pre-sync sum so voices chained in a ring cannot form a loop.
  always_comb begin
    unused_gate_s = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      sum_s[v]      = acc_q[v] + ACC_W'(bus.freq[16*v +: 16]);
      rise_s[v]     = ~bus.ctrl[8*v+3] & ~prev_msb_q[v] & sum_s[v][MSB];
      unused_gate_s = unused_gate_s ^ bus.ctrl[8*v];
    end
  end

  always_comb begin
    acc_d       = acc_q;
    lfsr_d      = lfsr_q;
    prev_msb_d  = prev_msb_q;
    prev_nbit_d = prev_nbit_q;
    if (bus.ce) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (bus.ctrl[8*v+3]) begin
          acc_d[v] = '0;
        end else if (bus.ctrl[8*v+1] && rise_s[prev_voice(v)]) begin
          acc_d[v] = '0;
        end else begin
          acc_d[v] = sum_s[v];
        end
        if (bus.ctrl[8*v+3]) begin
          lfsr_d[v] = '1;
        end else if (!prev_nbit_q[v] && acc_d[v][NBIT]) begin
          lfsr_d[v] = lfsr_step(lfsr_q[v]);
        end else begin
          lfsr_d[v] = lfsr_q[v];
        end
        prev_msb_d[v]  = acc_d[v][MSB];
        prev_nbit_d[v] = acc_d[v][NBIT];
      end
    end else begin
      acc_d  = acc_q;
      lfsr_d = lfsr_q;
    end
  end

  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      raw_s[v] = waveform(acc_q[v], acc_q[prev_voice(v)][MSB], lfsr_q[v],
                          bus.ctrl[8*v +: 8], bus.pw[OUT_W*v +: OUT_W]);
    end
  end

  // Output stage fires one clk after each accumulator update.
  always_comb begin
    ce_d        = bus.ce;
    wave_d      = wave_q;
    osc3_d      = osc3_q;
    out_valid_d = 1'b0;
    if (ce_q) begin
      out_valid_d = 1'b1;
      for (int v = 0; v < NUM_VOICES; v++) begin
        wave_d[OUT_W*v +: OUT_W] = scale(raw_s[v], bus.vol[VOL_W*v +: VOL_W]);
      end
      osc3_d = raw_s[LAST][OUT_W-1 -: 8];
    end else begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      lfsr_q      <= '1;
      prev_msb_q  <= '0;
      prev_nbit_q <= '0;
      ce_q        <= 1'b0;
      wave_q      <= '0;
      osc3_q      <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      lfsr_q      <= lfsr_d;
      prev_msb_q  <= prev_msb_d;
      prev_nbit_q <= prev_nbit_d;
      ce_q        <= ce_d;
      wave_q      <= wave_d;
      osc3_q      <= osc3_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.wave_out  = wave_q;
  assign bus.osc3      = osc3_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_sid_voice_bank.sv
// Directed bench for sid_voice_bank with hand-computed samples (vol=0xFF gives raw*255>>8).
module tb_sid_voice_bank;
  localparam int NV = 3;
  localparam int OW = 12;
  localparam int VW = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sid_voice_bank_if #(.NUM_VOICES(NV), .OUT_W(OW), .VOL_W(VW)) bus ();
  sid_voice_bank dut (.clk(clk), .reset(reset), .bus(bus));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [OW-1:0] wv(input int v);
    return bus.wave_out[OW*v +: OW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_ce(input int n);
    bus.ce = 1'b1;
    repeat (n) tick();
    bus.ce = 1'b0;
  endtask

  task automatic clear_inputs();
    bus.ce = 1'b0; bus.freq = '0; bus.pw = '0; bus.ctrl = '0; bus.vol = '0;
  endtask

  task automatic set_voice(input int v, input logic [15:0] f, input logic [7:0] c,
                           input logic [7:0] vl, input logic [11:0] p);
    bus.freq[16*v +: 16] = f;
    bus.ctrl[8*v +: 8]   = c;
    bus.vol[VW*v +: VW]  = vl;
    bus.pw[OW*v +: OW]   = p;
  endtask

  task automatic zero_voices();
    clear_inputs();
    bus.ctrl = 24'h080808;
    run_ce(1);
    tick();
    bus.ctrl = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    tick(); tick();
    checks++; if (bus.wave_out !== 36'h0) begin errors++; $display("FAIL reset_wave: got %h expected 0", bus.wave_out); end
    checks++; if (bus.osc3 !== 8'h00) begin errors++; $display("FAIL reset_osc3: got %h expected 00", bus.osc3); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_noise();
    clear_inputs();
    set_voice(0, 16'h0000, 8'h80, 8'hFF, 12'h000);
    set_voice(2, 16'h0000, 8'h80, 8'h00, 12'h000);
    run_ce(1);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL noise_latency: got %b expected 0", bus.out_valid); end
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL noise_valid: got %b expected 1", bus.out_valid); end
    checks++; if (wv(0) !== 12'hFE0) begin errors++; $display("FAIL noise_v0: got %h expected fe0", wv(0)); end
    checks++; if (bus.osc3 !== 8'hFF) begin errors++; $display("FAIL noise_osc3: got %h expected ff", bus.osc3); end
    checks++; if (wv(2) !== 12'h000) begin errors++; $display("FAIL noise_vol0: got %h expected 000", wv(2)); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL noise_pulse: got %b expected 0", bus.out_valid); end
    checks++; if (wv(0) !== 12'hFE0) begin errors++; $display("FAIL noise_hold: got %h expected fe0", wv(0)); end
  endtask

  task automatic test_lfsr();
    zero_voices();
    set_voice(0, 16'hFFFF, 8'h80, 8'hFF, 12'h000);
    run_ce(8); tick();
    checks++; if (wv(0) !== 12'hFE0) begin errors++; $display("FAIL lfsr_before: got %h expected fe0", wv(0)); end
    run_ce(1); tick();
    checks++; if (wv(0) !== 12'hFD0) begin errors++; $display("FAIL lfsr_step: got %h expected fd0", wv(0)); end
  endtask

  task automatic test_saw();
    zero_voices();
    set_voice(0, 16'h1000, 8'h20, 8'hFF, 12'h000);
    run_ce(16); tick();
    checks++; if (wv(0) !== 12'h00F) begin errors++; $display("FAIL saw_16: got %h expected 00f", wv(0)); end
    run_ce(1); tick();
    checks++; if (wv(0) !== 12'h010) begin errors++; $display("FAIL saw_17: got %h expected 010", wv(0)); end
  endtask

  task automatic test_sync();
    zero_voices();
    set_voice(0, 16'hFFFF, 8'h20, 8'hFF, 12'h000);
    set_voice(1, 16'h0100, 8'h22, 8'hFF, 12'h000);
    run_ce(128); tick();
    checks++; if (wv(0) !== 12'h7F7) begin errors++; $display("FAIL sync_v0_128: got %h expected 7f7", wv(0)); end
    checks++; if (wv(1) !== 12'h007) begin errors++; $display("FAIL sync_v1_128: got %h expected 007", wv(1)); end
    run_ce(1); tick();
    checks++; if (wv(0) !== 12'h806) begin errors++; $display("FAIL sync_v0_129: got %h expected 806", wv(0)); end
    checks++; if (wv(1) !== 12'h000) begin errors++; $display("FAIL sync_v1_129: got %h expected 000", wv(1)); end
    run_ce(128); tick();
    checks++; if (wv(0) !== 12'h00E) begin errors++; $display("FAIL wrap_v0_257: got %h expected 00e", wv(0)); end
    checks++; if (wv(1) !== 12'h007) begin errors++; $display("FAIL wrap_v1_257: got %h expected 007", wv(1)); end
  endtask

  task automatic test_pulse();
    zero_voices();
    set_voice(0, 16'hFFFF, 8'h40, 8'hFF, 12'h800);
    run_ce(1); tick();
    checks++; if (wv(0) !== 12'hFEF) begin errors++; $display("FAIL pulse_low: got %h expected fef", wv(0)); end
    run_ce(127); tick();
    checks++; if (wv(0) !== 12'hFEF) begin errors++; $display("FAIL pulse_7ff: got %h expected fef", wv(0)); end
    bus.pw[11:0] = 12'h80F;
    run_ce(1); tick();
    checks++; if (wv(0) !== 12'h000) begin errors++; $display("FAIL pulse_equal: got %h expected 000", wv(0)); end
    bus.pw[11:0] = 12'h800;
    run_ce(1); tick();
    checks++; if (wv(0) !== 12'h000) begin errors++; $display("FAIL pulse_high: got %h expected 000", wv(0)); end
  endtask

  task automatic test_tri_ring();
    zero_voices();
    set_voice(0, 16'hFFFF, 8'h00, 8'h00, 12'h000);
    set_voice(1, 16'h8000, 8'h14, 8'hFF, 12'h000);
    run_ce(128); tick();
    checks++; if (wv(1) !== 12'h7F8) begin errors++; $display("FAIL tri_ring_msb0: got %h expected 7f8", wv(1)); end
    bus.freq[31:16] = 16'h0000;
    run_ce(1); tick();
    checks++; if (wv(1) !== 12'h7F7) begin errors++; $display("FAIL tri_ring_msb1: got %h expected 7f7", wv(1)); end
    bus.ctrl[15:8] = 8'h04;
    run_ce(1); tick();
    checks++; if (wv(1) !== 12'h000) begin errors++; $display("FAIL no_wave: got %h expected 000", wv(1)); end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    bus.ce = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_first: got %b expected 0", bus.out_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d: got %b expected 1", i, bus.out_valid); end
    end
    bus.ce = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_last: got %b expected 1", bus.out_valid); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_reset_midstream();
    zero_voices();
    set_voice(0, 16'hFFFF, 8'h20, 8'hFF, 12'h000);
    set_voice(2, 16'h0000, 8'h80, 8'hFF, 12'h000);
    bus.ce = 1'b1;
    tick(); tick(); tick();
    checks++; if (bus.osc3 !== 8'hFF) begin errors++; $display("FAIL mid_pre_osc3: got %h expected ff", bus.osc3); end
    reset = 1'b1;
    #1;
    checks++; if (bus.wave_out !== 36'h0) begin errors++; $display("FAIL mid_wave: got %h expected 0", bus.wave_out); end
    checks++; if (bus.osc3 !== 8'h00) begin errors++; $display("FAIL mid_osc3: got %h expected 00", bus.osc3); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", bus.out_valid); end
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL post_first: got %b expected 0", bus.out_valid); end
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL post_valid: got %b expected 1", bus.out_valid); end
    checks++; if (wv(0) !== 12'h00E) begin errors++; $display("FAIL post_v0: got %h expected 00e", wv(0)); end
    checks++; if (bus.osc3 !== 8'hFF) begin errors++; $display("FAIL post_osc3: got %h expected ff", bus.osc3); end
    bus.ce = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_noise();
    test_lfsr();
    test_saw();
    test_sync();
    test_pulse();
    test_tri_ring();
    test_back_to_back();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
